// File: rtl/instr_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit_if
// Instruction-memory request/response bus between the fetch unit and the
// instruction memory. One request may be outstanding at a time; the request
// (req/addr) is held stable until the memory answers with ready/rdata.
//
// Signals
//   imem_req_o    fetch -> mem  request valid
//   imem_addr_o   fetch -> mem  request address (word aligned fetch PC)
//   imem_ready_i  mem -> fetch  response valid this cycle
//   imem_rdata_i  mem -> fetch  response instruction word
//
// Modports
//   master : the fetch unit (drives the request)
//   slave  : the instruction memory (drives the response)
// ----------------------------------------------------------------------------
interface instr_fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ready_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ready_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
// Sequential instruction fetcher feeding the IF/ID stage through a 2-entry
// queue of {pc_plus4, instr}. A small FSM (IDLE/REQ/DRAIN) issues at most one
// instruction-memory request at a time. Branch/jump redirects empty the queue,
// retarget the fetch PC and pulse flush_o for one cycle; a response that
// belongs to a request issued before a redirect is discarded.
//
// Ports
//   clk_i           clock, all state on posedge
//   rst_n_i         asynchronous active-low reset
//   stall_i         1 = IF/ID holding, head is not consumed
//   branch_taken_i  taken-branch redirect request
//   branch_addr_i   branch target
//   jump_i          jump redirect request (wins over branch)
//   jump_addr_i     jump target
//   imem            instruction-memory bus (master side)
//   addr_o          PC+4 of the head instruction
//   instr_o         head instruction, 0 (NOP) when the queue is empty
//   valid_o         queue non-empty
//   flush_o         one-cycle pulse on redirect
// ----------------------------------------------------------------------------
module instr_fetch_unit (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       stall_i,
  input  logic                       branch_taken_i,
  input  logic [31:0]                branch_addr_i,
  input  logic                       jump_i,
  input  logic [31:0]                jump_addr_i,
  instr_fetch_unit_if.master         imem,
  output logic [31:0]                addr_o,
  output logic [31:0]                instr_o,
  output logic                       valid_o,
  output logic                       flush_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Fetch FSM and PC
  state_e      state_q,    state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        req_q,      req_d;
  logic        flush_q,    flush_d;

  // Queue: entry 0 is always the head; entry 1 is only valid when entry 0 is.
  // Empty entries are kept at all-zero so the head registers can drive the
  // outputs directly (instr_o reads as NOP when the queue is empty).
  logic        e0_vld_q,   e0_vld_d;
  logic [31:0] e0_addr_q,  e0_addr_d;
  logic [31:0] e0_instr_q, e0_instr_d;
  logic        e1_vld_q,   e1_vld_d;
  logic [31:0] e1_addr_q,  e1_addr_d;
  logic [31:0] e1_instr_q, e1_instr_d;

  // Decoded control
  logic        redirect_s;
  logic [31:0] target_s;
  logic [31:0] pc_plus4_s;
  logic        resp_s;
  logic        push_s;
  logic        pop_s;
  logic        has_space_s;

  // Post-pop intermediate queue image
  logic        s0_vld_s;
  logic [31:0] s0_addr_s;
  logic [31:0] s0_instr_s;
  logic        s1_vld_s;
  logic [31:0] s1_addr_s;
  logic [31:0] s1_instr_s;

  // Redirect decode, response qualification and queue handshake terms
  always_comb begin
    redirect_s  = jump_i | branch_taken_i;
    target_s    = jump_i ? jump_addr_i : branch_addr_i;
    pc_plus4_s  = fetch_pc_q + 32'd4;
    has_space_s = ~e1_vld_q;
    // Only a response to a live REQ is ever pushed; DRAIN responses are dropped.
    resp_s      = (state_q == ST_REQ) & imem.imem_ready_i;
    push_s      = resp_s & ~redirect_s;
    pop_s       = ~stall_i & e0_vld_q & ~redirect_s;
  end

  // Fetch FSM next state and fetch PC update
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (redirect_s) begin
          fetch_pc_d = target_s;
          state_d    = ST_IDLE;
        end else if (has_space_s) begin
          state_d    = ST_REQ;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (redirect_s) begin
          fetch_pc_d = target_s;
          // A response arriving together with the redirect closes the
          // outstanding request, so there is nothing left to drain.
          if (imem.imem_ready_i) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (imem.imem_ready_i) begin
          fetch_pc_d = pc_plus4_s;
          state_d    = ST_IDLE;
        end else begin
          state_d    = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (redirect_s) begin
          fetch_pc_d = target_s;
        end else begin
          fetch_pc_d = fetch_pc_q;
        end
        // The stale response retires the old request whether or not a new
        // redirect arrives in the same cycle.
        if (imem.imem_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        fetch_pc_d = fetch_pc_q;
      end
    endcase
    req_d   = (state_d == ST_REQ);
    flush_d = redirect_s;
  end

  // Queue update: apply the pop (shift) first, then place the push in the
  // first free slot, so a simultaneous push/pop keeps count and order.
  always_comb begin
    if (pop_s) begin
      s0_vld_s   = e1_vld_q;
      s0_addr_s  = e1_addr_q;
      s0_instr_s = e1_instr_q;
      s1_vld_s   = 1'b0;
      s1_addr_s  = 32'd0;
      s1_instr_s = 32'd0;
    end else begin
      s0_vld_s   = e0_vld_q;
      s0_addr_s  = e0_addr_q;
      s0_instr_s = e0_instr_q;
      s1_vld_s   = e1_vld_q;
      s1_addr_s  = e1_addr_q;
      s1_instr_s = e1_instr_q;
    end

    e0_vld_d   = s0_vld_s;
    e0_addr_d  = s0_addr_s;
    e0_instr_d = s0_instr_s;
    e1_vld_d   = s1_vld_s;
    e1_addr_d  = s1_addr_s;
    e1_instr_d = s1_instr_s;

    if (redirect_s) begin
      e0_vld_d   = 1'b0;
      e0_addr_d  = 32'd0;
      e0_instr_d = 32'd0;
      e1_vld_d   = 1'b0;
      e1_addr_d  = 32'd0;
      e1_instr_d = 32'd0;
    end else if (push_s) begin
      if (!s0_vld_s) begin
        e0_vld_d   = 1'b1;
        e0_addr_d  = pc_plus4_s;
        e0_instr_d = imem.imem_rdata_i;
      end else if (!s1_vld_s) begin
        e1_vld_d   = 1'b1;
        e1_addr_d  = pc_plus4_s;
        e1_instr_d = imem.imem_rdata_i;
      end else begin
        // Unreachable: requests are only issued while a slot is free.
        e1_vld_d   = s1_vld_s;
      end
    end else begin
      e0_vld_d   = s0_vld_s;
    end
  end

  // FSM, fetch PC and registered bus/flush outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= 32'd0;
      req_q      <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      flush_q    <= flush_d;
    end
  end

  // Queue storage
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      e0_vld_q   <= 1'b0;
      e0_addr_q  <= 32'd0;
      e0_instr_q <= 32'd0;
      e1_vld_q   <= 1'b0;
      e1_addr_q  <= 32'd0;
      e1_instr_q <= 32'd0;
    end else begin
      e0_vld_q   <= e0_vld_d;
      e0_addr_q  <= e0_addr_d;
      e0_instr_q <= e0_instr_d;
      e1_vld_q   <= e1_vld_d;
      e1_addr_q  <= e1_addr_d;
      e1_instr_q <= e1_instr_d;
    end
  end

  // The request address is the fetch PC itself, which is frozen while in REQ.
  assign imem.imem_req_o  = req_q;
  assign imem.imem_addr_o = fetch_pc_q;

  assign addr_o  = e0_addr_q;
  assign instr_o = e0_instr_q;
  assign valid_o = e0_vld_q;
  assign flush_o = flush_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_addr_i;
  logic        jump_i;
  logic [31:0] jump_addr_i;
  logic [31:0] addr_o;
  logic [31:0] instr_o;
  logic        valid_o;
  logic        flush_o;

  instr_fetch_unit_if intf ();

  instr_fetch_unit dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .stall_i        (stall_i),
    .branch_taken_i (branch_taken_i),
    .branch_addr_i  (branch_addr_i),
    .jump_i         (jump_i),
    .jump_addr_i    (jump_addr_i),
    .imem           (intf.master),
    .addr_o         (addr_o),
    .instr_o        (instr_o),
    .valid_o        (valid_o),
    .flush_o        (flush_o)
  );

  always #5 clk_i = ~clk_i;

  // memory responder state
  int          mem_lat = 0;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata = 32'd0;
  logic        stray_ready = 1'b0;
  assign intf.imem_ready_i = resp_ready | stray_ready;
  assign intf.imem_rdata_i = resp_rdata;

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic [31:0] req_log[$];
  logic [31:0] pop_addr[$];
  logic [31:0] pop_instr[$];
  logic        prev_req  = 1'b0;
  logic [31:0] prev_addr = 32'd0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // memory: latches the address of a new request, answers after mem_lat cycles
  initial begin
    logic        pending;
    logic [31:0] paddr;
    int          waitc;
    pending = 1'b0;
    paddr   = 32'd0;
    waitc   = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_n_i) begin
        resp_ready = 1'b0;
        pending    = 1'b0;
        waitc      = 0;
      end else if (resp_ready) begin
        resp_ready = 1'b0;
        pending    = 1'b0;
        waitc      = 0;
      end else if (pending || intf.imem_req_o) begin
        if (!pending) begin
          pending = 1'b1;
          paddr   = intf.imem_addr_o;
        end
        if (waitc >= mem_lat) begin
          resp_ready = 1'b1;
          resp_rdata = mem_word(paddr);
        end else begin
          waitc++;
        end
      end
    end
  end

  // log the head consumed at the coming edge and any new request, then advance
  task automatic step();
    if (valid_o && !stall_i && !(jump_i || branch_taken_i)) begin
      pop_addr.push_back(addr_o);
      pop_instr.push_back(instr_o);
    end
    if (intf.imem_req_o && !(prev_req && prev_addr == intf.imem_addr_o))
      req_log.push_back(intf.imem_addr_o);
    prev_req  = intf.imem_req_o;
    prev_addr = intf.imem_addr_o;
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_req(input string tag, input int idx, input logic [31:0] exp);
    logic [31:0] got;
    got = (idx < req_log.size()) ? req_log[idx] : 32'hBAD0_BAD0;
    check_val(tag, got, exp);
  endtask

  task automatic expect_pop(input string tag, input int idx, input logic [31:0] exp_addr);
    logic [31:0] ga;
    logic [31:0] gi;
    ga = (idx < pop_addr.size())  ? pop_addr[idx]  : 32'hBAD0_BAD0;
    gi = (idx < pop_instr.size()) ? pop_instr[idx] : 32'hBAD0_BAD0;
    check_val({tag, "_addr"}, ga, exp_addr);
    check_val({tag, "_instr"}, gi, mem_word(exp_addr - 32'd4));
  endtask

  task automatic wait_req(input string tag, input logic level, input int max_cyc);
    int n;
    n = 0;
    while (intf.imem_req_o !== level && n < max_cyc) begin
      step();
      n++;
    end
    check_val(tag, {31'd0, intf.imem_req_o}, {31'd0, level});
  endtask

  initial begin
    int r;
    int p;
    logic [31:0] last;
    rst_n_i        = 1'b1;
    stall_i        = 1'b0;
    branch_taken_i = 1'b0;
    branch_addr_i  = 32'd0;
    jump_i         = 1'b0;
    jump_addr_i    = 32'd0;
    #2 rst_n_i = 1'b0;
    #10;
    check_val("rst_req",   {31'd0, intf.imem_req_o}, 32'd0);
    check_val("rst_iaddr", intf.imem_addr_o, 32'd0);
    check_val("rst_valid", {31'd0, valid_o}, 32'd0);
    check_val("rst_addr",  addr_o, 32'd0);
    check_val("rst_instr", instr_o, 32'd0);
    check_val("rst_flush", {31'd0, flush_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;

    // sequential fetch from 0
    repeat (12) step();
    expect_req("t1_req0", 0, 32'h0);
    expect_req("t1_req1", 1, 32'h4);
    expect_req("t1_req2", 2, 32'h8);
    expect_pop("t1_pop0", 0, 32'h4);
    expect_pop("t1_pop1", 1, 32'h8);

    // stall fills the queue and stops fetching
    last = pop_addr[pop_addr.size() - 1];
    stall_i = 1'b1;
    repeat (10) step();
    check_val("t2_valid", {31'd0, valid_o}, 32'd1);
    check_val("t2_noreq", {31'd0, intf.imem_req_o}, 32'd0);
    check_val("t2_head_addr", addr_o, last + 32'd4);
    check_val("t2_head_instr", instr_o, mem_word(last));
    stall_i = 1'b0;
    p = pop_addr.size();
    repeat (10) step();
    expect_pop("t2_rel0", p,     last + 32'd4);
    expect_pop("t2_rel1", p + 1, last + 32'd8);
    expect_pop("t2_rel2", p + 2, last + 32'd12);

    // branch with a full queue
    stall_i = 1'b1;
    repeat (8) step();
    check_val("t3_full_valid", {31'd0, valid_o}, 32'd1);
    check_val("t3_full_noreq", {31'd0, intf.imem_req_o}, 32'd0);
    branch_taken_i = 1'b1;
    branch_addr_i  = 32'h100;
    step();
    branch_taken_i = 1'b0;
    r = req_log.size();
    p = pop_addr.size();
    check_val("t3_flush_hi", {31'd0, flush_o}, 32'd1);
    check_val("t3_empty", {31'd0, valid_o}, 32'd0);
    check_val("t3_nop", instr_o, 32'd0);
    step();
    check_val("t3_flush_lo", {31'd0, flush_o}, 32'd0);
    stall_i = 1'b0;
    repeat (6) step();
    expect_req("t3_req", r, 32'h100);
    expect_pop("t3_pop", p, 32'h104);

    // redirect with a request outstanding; its response arrives in DRAIN
    mem_lat = 3;
    wait_req("t4_wait_lo", 1'b0, 20);
    wait_req("t4_wait_hi", 1'b1, 20);
    branch_taken_i = 1'b1;
    branch_addr_i  = 32'h200;
    step();
    branch_taken_i = 1'b0;
    check_val("t4_dropreq", {31'd0, intf.imem_req_o}, 32'd0);
    r = req_log.size();
    p = pop_addr.size();
    repeat (14) step();
    expect_req("t4_req", r, 32'h200);
    expect_pop("t4_pop", p, 32'h204);

    // jump beats branch; redirect coincides with the response
    mem_lat = 0;
    wait_req("t5_wait_lo", 1'b0, 20);
    wait_req("t5_wait_hi", 1'b1, 20);
    jump_i         = 1'b1;
    jump_addr_i    = 32'h300;
    branch_taken_i = 1'b1;
    branch_addr_i  = 32'h400;
    step();
    jump_i         = 1'b0;
    branch_taken_i = 1'b0;
    p = pop_addr.size();
    check_val("t5_req_lo", {31'd0, intf.imem_req_o}, 32'd0);
    step();
    check_val("t5_req_hi", {31'd0, intf.imem_req_o}, 32'd1);
    check_val("t5_req_addr", intf.imem_addr_o, 32'h300);
    repeat (4) step();
    expect_pop("t5_pop", p, 32'h304);

    // wrap-around at the top of the address space
    branch_taken_i = 1'b1;
    branch_addr_i  = 32'hFFFF_FFFC;
    step();
    branch_taken_i = 1'b0;
    r = req_log.size();
    p = pop_addr.size();
    repeat (10) step();
    expect_req("t6_req0", r,     32'hFFFF_FFFC);
    expect_req("t6_req1", r + 1, 32'h0);
    expect_pop("t6_pop", p, 32'h0);

    // reset in the middle of a request, then a stray ready
    mem_lat = 5;
    wait_req("t7_wait_lo", 1'b0, 20);
    wait_req("t7_wait_hi", 1'b1, 20);
    rst_n_i = 1'b0;
    #1;
    check_val("t7_rst_req",   {31'd0, intf.imem_req_o}, 32'd0);
    check_val("t7_rst_iaddr", intf.imem_addr_o, 32'd0);
    check_val("t7_rst_valid", {31'd0, valid_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_n_i     = 1'b1;
    stray_ready = 1'b1;
    step();
    stray_ready = 1'b0;
    check_val("t7_nopush", {31'd0, valid_o}, 32'd0);
    r = req_log.size();
    p = pop_addr.size();
    repeat (14) step();
    expect_req("t7_req", r, 32'h0);
    expect_pop("t7_pop", p, 32'h4);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have port clk_i  input  1  single clock; all state updates on posedge.
REQ-002 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port stall_i  input  1  1 = downstream IF/ID holding, no pop.
REQ-004 SHALL have port branch_taken_i  input  1  taken-branch redirect request.
REQ-005 SHALL have port branch_addr_i  input  32  branch target.
REQ-006 SHALL have port jump_i  input  1  jump redirect request.
REQ-007 SHALL have port jump_addr_i  input  32  jump target.
REQ-008 SHALL have port imem_req_o  output  1  instruction-memory request.
REQ-009 SHALL have port imem_addr_o  output  32  request address (current fetch PC).
REQ-010 SHALL have port imem_ready_i  input  1  response valid this cycle.
REQ-011 SHALL have port imem_rdata_i  input  32  response instruction.
REQ-012 SHALL have port addr_o  output  32  PC+4 of the head instruction, to IF/ID addr_i.
REQ-013 SHALL have port instr_o  output  32  head instruction, or 0 (NOP) when the queue is empty.
REQ-014 SHALL have port valid_o  output  1  1 = queue non-empty and addr_o/instr_o meaningful.
REQ-015 SHALL have port flush_o  output  1  one-cycle pulse to IF/ID flush_i on redirect.

Function
REQ-016 SHALL hold a 2-entry FIFO of {pc_plus4, instr}; addr_o/instr_o/valid_o SHALL be driven from the head registers only (no combinational path from imem_rdata_i).
REQ-017 SHALL implement fetch FSM states IDLE, REQ, DRAIN; at most one memory request outstanding.
REQ-018 IDLE: if queue count < 2 and no redirect, SHALL go to REQ and assert imem_req_o with imem_addr_o = fetch_pc from the next cycle.
REQ-019 REQ: imem_req_o and imem_addr_o SHALL stay stable until imem_ready_i; on ready SHALL push {fetch_pc+4, imem_rdata_i}, set fetch_pc <= fetch_pc+4 and return to IDLE.
REQ-020 Redirect = jump_i | branch_taken_i; target = jump_addr_i if jump_i else branch_addr_i (jump has priority when both are asserted).
REQ-021 On redirect SHALL, next edge: empty the FIFO, set fetch_pc <= target, assert flush_o for exactly one cycle; redirect overrides stall_i.
REQ-022 Redirect in REQ without imem_ready_i SHALL go to DRAIN and drop imem_req_o; DRAIN SHALL discard the response on imem_ready_i, then go to IDLE.
REQ-023 Redirect in REQ in the same cycle as imem_ready_i SHALL discard that response and go to IDLE (not DRAIN).
REQ-024 Redirect while in DRAIN SHALL update fetch_pc to the new target and remain in DRAIN.
REQ-025 Pop SHALL occur when stall_i=0, count>0 and no redirect; simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-026 A push SHALL never be attempted at count=2 (guaranteed by REQ-018); with stall_i=1 the FIFO SHALL fill to 2 and fetching SHALL stop.
REQ-027 fetch_pc and pc_plus4 arithmetic SHALL be 32-bit modulo: 0xFFFFFFFC+4 = 0x00000000.

Reset
REQ-028 While rst_n_i=0 SHALL immediately force: fetch_pc=0, FIFO empty, FSM=IDLE, imem_req_o=0, imem_addr_o=0, addr_o=0, instr_o=0, valid_o=0, flush_o=0.
REQ-029 Reset asserted mid-request SHALL abandon it; a later imem_ready_i SHALL be ignored until a new request is issued.

Verification
REQ-030 Release reset, memory ready one cycle after each request, stall_i=0 -> requests to 0x0, 0x4, 0x8; valid_o outputs (addr_o, instr) = (0x4, M[0]), (0x8, M[4]) in order.
REQ-031 stall_i=1 for 10 cycles -> exactly 2 entries held, imem_req_o=0 afterwards, head output unchanged; release -> both entries pop in order, fetch resumes.
REQ-032 branch_taken_i=1, branch_addr_i=0x100 with queue full -> flush_o high one cycle, valid_o=0, next request address 0x100.
REQ-033 Redirect to 0x200 while a request is outstanding, ready three cycles later -> that response dropped, no push, next request address 0x200.
REQ-034 jump_i=1 (0x300) together with branch_taken_i=1 (0x400) -> next request address 0x300.
REQ-035 Redirect to 0xFFFFFFFC -> entry addr_o=0x00000000, following request address 0x00000000.
